mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between two requesters: the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Sequences each access through a fixed-latency memory and returns read data with a one-cycle ack pulse.
- Drives stall_if / stall_mem so the pipeline freezes the affected stages while a request is pending.
- Sits between Fetch_Stage / Memory_Stage and the memory macro.

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one fixed-latency single-port memory.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, stateNext;
  logic [CW-1:0] latCnt;
  logic          ownerData;
  logic          isStore;
  logic          grantData;
  logic          grantFetch;
  logic          fetchForce;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starveCnt;

  // Qualified by if_req so a just-dropped fetch cannot block a pending data access.
  assign fetchForce = if_req && (starveCnt == SW'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      starveCnt <= '0;
    end else if (!if_req || grantFetch) begin
      starveCnt <= '0;
    end else if (grantData) begin
      starveCnt <= starveCnt + SW'(1);
    end
  end
`else
  // Strict data priority; STARVE_MAX only matters when the guard is built in.
  assign fetchForce = (STARVE_MAX < 0);
`endif

  always_comb begin
    stateNext  = state;
    grantData  = 1'b0;
    grantFetch = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !fetchForce) begin
          grantData = 1'b1;
          stateNext = ISSUE;
        end else if (if_req) begin
          grantFetch = 1'b1;
          stateNext  = ISSUE;
        end
      end
      ISSUE:   stateNext = isStore ? RESP : WAIT;
      WAIT:    if (latCnt == CW'(1)) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      latCnt    <= '0;
      ownerData <= 1'b0;
      isStore   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state  <= stateNext;
      mem_en <= grantData || grantFetch;
      mem_we <= grantData && d_we;
      if (grantData || grantFetch) begin
        mem_addr  <= grantData ? d_addr : if_addr;
        ownerData <= grantData;
        isStore   <= grantData && d_we;
      end
      if (grantData) mem_wdata <= d_wdata;

      if (state == ISSUE) begin
        latCnt <= CW'(MEM_LAT);
      end else if (state == WAIT) begin
        latCnt <= latCnt - CW'(1);
      end

      // Counter is about to hit zero: mem_rdata is valid in this cycle.
      if (state == WAIT && latCnt == CW'(1)) begin
        if (ownerData) d_rdata <= mem_rdata;
        else           if_rdata <= mem_rdata;
      end

      if_ack <= (stateNext == RESP) && !ownerData;
      d_ack  <= (stateNext == RESP) && ownerData;
    end
  end

  assign stall_if  = if_req && !if_ack && !reset;
  assign stall_mem = d_req && !d_ack && !reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a cycle-tagged scoreboard of issues and acks.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_ack, d_ack, stall_if, stall_mem, mem_en, mem_we;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pat(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return 16'(a * 16'd257) ^ 16'h3C5A;
  endfunction

  // Memory macro: fixed read latency LAT after the mem_en cycle.
  logic [15:0] memArr [0:1023];
  logic [15:0] pipe [0:LAT-1];
  bit          memLoaded = 1'b0;
  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int i = 0; i < 1024; i++) memArr[i] <= pat(16'(i));
      memLoaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      memArr[mem_addr[9:0]] <= mem_wdata;
    end
    pipe[0] <= memArr[mem_addr[9:0]];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  typedef struct { int due; logic isData; logic isLoad; logic [15:0] data; } ack_t;
  typedef struct { int due; logic [15:0] addr; logic we; logic [15:0] wdata; } iss_t;
  ack_t ackQ[$];
  iss_t issQ[$];

  int          tests = 0;
  int          fails = 0;
  logic        autoDrop;
  logic [15:0] expI, expD;
  int          t0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic pushIssue(input int due, input logic [15:0] a, input logic we, input logic [15:0] wd);
    iss_t e;
    e.due = due; e.addr = a; e.we = we; e.wdata = wd;
    issQ.push_back(e);
  endtask

  task automatic pushAck(input int due, input logic isData, input logic isLoad, input logic [15:0] data);
    ack_t e;
    e.due = due; e.isData = isData; e.isLoad = isLoad; e.data = data;
    ackQ.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCycle();
    logic eIfAck, eDAck, eEn;
    #1;
    eIfAck = 1'b0;
    eDAck  = 1'b0;
    if (ackQ.size() > 0 && ackQ[0].due == cyc) begin
      eIfAck = !ackQ[0].isData;
      eDAck  = ackQ[0].isData;
      if (ackQ[0].isLoad) begin
        if (ackQ[0].isData) expD = ackQ[0].data;
        else                expI = ackQ[0].data;
      end
      void'(ackQ.pop_front());
    end
    check("if_ack", 32'(if_ack), 32'(eIfAck));
    check("d_ack", 32'(d_ack), 32'(eDAck));
    check("if_rdata", 32'(if_rdata), 32'(expI));
    check("d_rdata", 32'(d_rdata), 32'(expD));
    check("stall_if", 32'(stall_if), 32'(if_req && !eIfAck && !reset));
    check("stall_mem", 32'(stall_mem), 32'(d_req && !eDAck && !reset));

    eEn = (issQ.size() > 0 && issQ[0].due == cyc);
    check("mem_en", 32'(mem_en), 32'(eEn));
    if (eEn) begin
      check("mem_addr", 32'(mem_addr), 32'(issQ[0].addr));
      check("mem_we", 32'(mem_we), 32'(issQ[0].we));
      if (issQ[0].we) check("mem_wdata", 32'(mem_wdata), 32'(issQ[0].wdata));
      void'(issQ.pop_front());
    end else begin
      check("mem_we_idle", 32'(mem_we), 32'd0);
    end

    if (autoDrop && eIfAck) if_req = 1'b0;
    if (autoDrop && eDAck)  d_req  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      nextCycle();
      checkCycle();
    end
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 16'h0030; d_addr = 16'h0040; d_wdata = 16'h0000;
    autoDrop = 1'b1; expI = 16'h0; expD = 16'h0;

    // Reset held two cycles with both requests high.
    nextCycle();
    checkCycle();
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    nextCycle();
    reset = 1'b0;
    t0 = cyc;
    pushIssue(t0 + 1, 16'h0040, 1'b0, 16'h0);
    pushAck(t0 + 4, 1'b1, 1'b1, pat(16'h0040));
    checkCycle();
    // Requests dropped before ack: the load still completes.
    nextCycle();
    if_req = 1'b0; d_req = 1'b0;
    checkCycle();
    idle(5);

    // Single fetch, latency and stall profile.
    nextCycle();
    t0 = cyc;
    if_req = 1'b1; if_addr = 16'h0010;
    pushIssue(t0 + 1, 16'h0010, 1'b0, 16'h0);
    pushAck(t0 + 4, 1'b0, 1'b1, 16'hBEEF);
    checkCycle();
    idle(6);

    // Simultaneous fetch and load: data first, fetch after.
    nextCycle();
    t0 = cyc;
    if_req = 1'b1; if_addr = 16'h0020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
    pushIssue(t0 + 1, 16'h0100, 1'b0, 16'h0);
    pushAck(t0 + 4, 1'b1, 1'b1, pat(16'h0100));
    pushIssue(t0 + 6, 16'h0020, 1'b0, 16'h0);
    pushAck(t0 + 9, 1'b0, 1'b1, pat(16'h0020));
    checkCycle();
    idle(11);

    // Store: ack two cycles later, d_rdata untouched.
    nextCycle();
    t0 = cyc;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
    pushIssue(t0 + 1, 16'h0200, 1'b1, 16'h1234);
    pushAck(t0 + 2, 1'b1, 1'b0, 16'h0);
    checkCycle();
    idle(3);

    // Load back the stored word.
    nextCycle();
    t0 = cyc;
    d_req = 1'b1; d_we = 1'b0;
    pushIssue(t0 + 1, 16'h0200, 1'b0, 16'h0);
    pushAck(t0 + 4, 1'b1, 1'b1, 16'h1234);
    checkCycle();
    idle(6);

    // Reset during WAIT aborts the fetch with no ack.
    nextCycle();
    t0 = cyc;
    if_req = 1'b1; if_addr = 16'h0030;
    pushIssue(t0 + 1, 16'h0030, 1'b0, 16'h0);
    checkCycle();
    idle(1);
    nextCycle();
    reset = 1'b1; if_req = 1'b0;
    checkCycle();
    nextCycle();
    reset = 1'b0; expI = 16'h0; expD = 16'h0;
    checkCycle();
    idle(6);

    // Continuous loads with a pending fetch.
    nextCycle();
    t0 = cyc;
    autoDrop = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
    if_req = 1'b1; if_addr = 16'h0020;
    for (int k = 0; k < 4; k++) begin
      pushIssue(t0 + 5 * k + 1, 16'h0100, 1'b0, 16'h0);
      pushAck(t0 + 5 * k + 4, 1'b1, 1'b1, pat(16'h0100));
    end
`ifdef ARB_STARVE_GUARD_EN
    pushIssue(t0 + 21, 16'h0020, 1'b0, 16'h0);
    pushAck(t0 + 24, 1'b0, 1'b1, pat(16'h0020));
`else
    pushIssue(t0 + 21, 16'h0100, 1'b0, 16'h0);
    pushAck(t0 + 24, 1'b1, 1'b1, pat(16'h0100));
`endif
    checkCycle();
    idle(24);
    if_req = 1'b0; d_req = 1'b0; autoDrop = 1'b1;
    idle(4);

    check("ackQ_empty", 32'(ackQ.size()), 32'd0);
    check("issQ_empty", 32'(issQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
